// File: rtl/bbq_op_router.sv
// rtl/bbq_op_router.sv - routes dequeue requests and buffered enqueues onto rotating heap lanes
// Optional per-op issue counters are enabled by defining BBQ_OP_ROUTER_STATS_EN.

package bbq_op_router_pkg;
  typedef enum logic [1:0] {
    HEAP_OP_ENQUE     = 2'd0,
    HEAP_OP_DEQUE_MIN = 2'd1,
    HEAP_OP_DEQUE_MAX = 2'd2,
    HEAP_OP_PEEK      = 2'd3
  } heap_op_t;
endpackage

module bbq_op_router
  import bbq_op_router_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int NUM_LANES   = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bbq_rdy,
  input  logic                             in_enque_en,
  input  logic [DWIDTH-1:0]                in_data,
  input  logic [PRIOR_WIDTH-1:0]           in_prior,
  output logic                             in_enque_rdy,
  input  logic                             deq_en,
  input  heap_op_t                         deq_op,
  output logic                             deq_rdy,
  output logic [NUM_LANES-1:0]             out_valid,
  output heap_op_t                         out_op_type [NUM_LANES],
  output logic [NUM_LANES*DWIDTH-1:0]      out_he_data,
  output logic [NUM_LANES*PRIOR_WIDTH-1:0] out_he_priority
`ifdef BBQ_OP_ROUTER_STATS_EN
  ,
  output logic [31:0]                      stat_enq_cnt,
  output logic [31:0]                      stat_deq_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(NUM_LANES);

  logic [DWIDTH-1:0]      fifo_data  [FIFO_DEPTH];
  logic [PRIOR_WIDTH-1:0] fifo_prior [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [LW-1:0]          base_ptr;

  logic          push;
  logic          deq_issue;
  logic          enq_issue;
  logic [LW-1:0] enq_lane;

  logic [NUM_LANES-1:0]             nxt_valid;
  heap_op_t                         nxt_op [NUM_LANES];
  logic [NUM_LANES*DWIDTH-1:0]      nxt_data;
  logic [NUM_LANES*PRIOR_WIDTH-1:0] nxt_prio;

  // Full-ness comes from the registered count only, so a same-cycle pop never opens a slot.
  assign in_enque_rdy = (count < (AW+1)'(FIFO_DEPTH));
  assign push         = in_enque_en && in_enque_rdy;
  assign deq_rdy      = bbq_rdy;
  assign deq_issue    = bbq_rdy && deq_en;
  assign enq_issue    = bbq_rdy && (count != '0);
  assign enq_lane     = deq_issue ? base_ptr + LW'(1) : base_ptr;

  always_comb begin
    nxt_valid = '0;
    nxt_data  = '0;
    nxt_prio  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      nxt_op[i] = HEAP_OP_ENQUE;
    end
    if (deq_issue) begin
      nxt_valid[base_ptr] = 1'b1;
      nxt_op[base_ptr]    = deq_op;
    end
    if (enq_issue) begin
      nxt_valid[enq_lane]                                   = 1'b1;
      nxt_op[enq_lane]                                      = HEAP_OP_ENQUE;
      nxt_data[int'(enq_lane)*DWIDTH +: DWIDTH]             = fifo_data[rd_ptr];
      nxt_prio[int'(enq_lane)*PRIOR_WIDTH +: PRIOR_WIDTH]   = fifo_prior[rd_ptr];
    end
  end

  // Storage is not reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= in_data;
      fifo_prior[wr_ptr] <= in_prior;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      base_ptr        <= '0;
      out_valid       <= '0;
      out_he_data     <= '0;
      out_he_priority <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        out_op_type[i] <= HEAP_OP_ENQUE;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (enq_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !enq_issue) begin
        count <= count + (AW+1)'(1);
      end else if (!push && enq_issue) begin
        count <= count - (AW+1)'(1);
      end
      base_ptr        <= base_ptr + LW'(deq_issue) + LW'(enq_issue);
      out_valid       <= nxt_valid;
      out_he_data     <= nxt_data;
      out_he_priority <= nxt_prio;
      for (int i = 0; i < NUM_LANES; i++) begin
        out_op_type[i] <= nxt_op[i];
      end
    end
  end

`ifdef BBQ_OP_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq_cnt <= '0;
      stat_deq_cnt <= '0;
    end else begin
      stat_enq_cnt <= stat_enq_cnt + 32'(enq_issue);
      stat_deq_cnt <= stat_deq_cnt + 32'(deq_issue);
    end
  end
`endif

endmodule

// File: doc/bbq_op_router.md
BBQ_OP_ROUTER -- requirements
Module: bbq_op_router

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 32, payload width; PRIOR_WIDTH, default 6, priority width; NUM_LANES, default 2, output lanes (2, 4 or 8); FIFO_DEPTH, default 4, enqueue buffer entries (power of 2, >=2).
REQ-002 Ports SHALL be, name direction width meaning:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- bbq_rdy  in  1  downstream heap can accept ops this cycle.
- in_enque_en  in  1  enqueue request valid.
- in_data  in  DWIDTH  enqueue payload.
- in_prior  in  PRIOR_WIDTH  enqueue priority.
- in_enque_rdy  out  1  enqueue FIFO not full.
- deq_en  in  1  dequeue request valid.
- deq_op  in  heap_op_t  op type issued for the dequeue request.
- deq_rdy  out  1  dequeue accepted this cycle; equals bbq_rdy.
- out_valid  out  NUM_LANES  per-lane op valid.
- out_op_type  out  NUM_LANES x heap_op_t  per-lane op type.
- out_he_data  out  NUM_LANES*DWIDTH  per-lane payload; lane i at bits [i*DWIDTH +: DWIDTH].
- out_he_priority  out  NUM_LANES*PRIOR_WIDTH  per-lane priority, packed the same way.
REQ-003 Clocking and reset SHALL be exactly: one clock, clk; reset rst, synchronous and active-high.

Function
REQ-004 Push: an enqueue SHALL be written into the FIFO when in_enque_en && in_enque_rdy.
REQ-005 in_enque_rdy SHALL be derived from registered occupancy only, as count < FIFO_DEPTH.
- A same-cycle pop SHALL NOT free a slot for a push while full.
REQ-006 Occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 Issue SHALL occur only in cycles where bbq_rdy=1.
- The dequeue (if deq_en) SHALL take lane base_ptr.
- The FIFO head (if non-empty) SHALL take lane (base_ptr+1) mod NUM_LANES when a dequeue issues, else lane base_ptr.
- The FIFO head SHALL pop in the same cycle it issues.
REQ-008 base_ptr SHALL advance by the number of ops issued (0, 1 or 2), modulo NUM_LANES.
REQ-009 Output registers SHALL update at the clock edge after issue.
- Issued lanes: valid=1, with op type/data/priority from the issued op.
- Dequeue lanes: op type = deq_op, data 0, priority 0.
- Enqueue lanes: op type = HEAP_OP_ENQUE.
- All other lanes: valid=0, op type HEAP_OP_ENQUE, data 0, priority 0.
REQ-010 Latency SHALL be 1 cycle for dequeue (request to out_valid).
- Enqueue SHALL take 2 cycles minimum (push to out_valid); there is no FIFO bypass.
REQ-011 When bbq_rdy=0:
- all out_valid SHALL be 0 on the next cycle;
- FIFO contents and base_ptr SHALL hold;
- pushes SHALL still be accepted while not full.
REQ-012 Simultaneous push and pop on a non-full FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-013 deq_en while bbq_rdy=0 SHALL be dropped (deq_rdy=0); the requester holds the request.

Reset
REQ-014 On rst=1 at a clock edge, the following SHALL clear: count, read/write pointers, base_ptr, all out_valid, out_he_data and out_he_priority.
REQ-015 On reset, every out_op_type SHALL become HEAP_OP_ENQUE and in_enque_rdy SHALL become 1.
REQ-016 Reset mid-operation SHALL discard buffered enqueues; no op SHALL issue in the reset cycle.

Configuration
REQ-017 Macro BBQ_OP_ROUTER_STATS_EN SHALL gate the statistics feature.
- When defined, the block SHALL add 32-bit outputs stat_enq_cnt and stat_deq_cnt, counting issued enqueues and dequeues.
- The counters SHALL wrap at 2^32 and SHALL clear on rst.
- When undefined, these ports and registers SHALL not exist.

Verification
REQ-018 Benches SHALL use NUM_LANES=4, FIFO_DEPTH=4 and cover the following scenarios.
- Reset: rst for 2 cycles -> out_valid=4'b0000, in_enque_rdy=1, base_ptr=0.
- Single dequeue: bbq_rdy=1, deq_en=1 at cycle 0 -> cycle 1: out_valid=4'b0001, lane0 op=deq_op; base_ptr=1.
- Paired issue: push data 0xA5 prior 3, then dequeue next cycle with base_ptr=1 -> lane1=dequeue, lane2=ENQUE 0xA5/3, out_valid=4'b0110, base_ptr=3.
- Full: bbq_rdy=0, push 5 items -> first 4 accepted, in_enque_rdy=0 on the 5th; bbq_rdy=1 -> items issue in order over 4 cycles.
- Wrap: 6 consecutive dequeues -> lanes 0,1,2,3,0,1.
- Stats (macro defined): 3 enqueues + 2 dequeues issued -> stat_enq_cnt=3, stat_deq_cnt=2.
